// File: rtl/id_pkg.sv
// Shared decode constants for the RV32I ID stage: opcode classes, control-bundle bit positions, CTRL_W.
// ID_RV32M_EN adds the 'mdu' control bit as the bundle MSB.
package id_pkg;

   localparam logic [6:0] INSTR_TYPE_R   = 7'b0110011;
   localparam logic [6:0] INSTR_TYPE_I   = 7'b0010011;
   localparam logic [6:0] INSTR_TYPE_IL  = 7'b0000011;
   localparam logic [6:0] INSTR_TYPE_S   = 7'b0100011;
   localparam logic [6:0] INSTR_TYPE_B   = 7'b1100011;
   localparam logic [6:0] INSTR_TYPE_J   = 7'b1101111;
   localparam logic [6:0] INSTR_TYPE_JR  = 7'b1100111;
   localparam logic [6:0] INSTR_TYPE_U   = 7'b0110111;
   localparam logic [6:0] INSTR_TYPE_UPC = 7'b0010111;

   localparam logic [6:0] FUNCT7_MULDIV  = 7'b0000001;

   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMWRITE = 1;
   localparam int CTRL_MEMTOREG = 2;
   localparam int CTRL_MEMREAD  = 3;
   localparam int CTRL_BRANCH   = 4;
   localparam int CTRL_JUMP     = 5;
   localparam int CTRL_ALUSRC   = 6;
   localparam int CTRL_MDU      = 7;

`ifdef ID_RV32M_EN
   localparam int CTRL_W = 8;
`else
   localparam int CTRL_W = 7;
`endif

endpackage

// File: rtl/id_imm_gen.sv
// Combinational RV32I immediate generator: picks the immediate format from the opcode and
// sign-extends it to XLEN. Unaffected by ID_RV32M_EN (R-type carries no immediate).
module id_imm_gen
   import id_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   logic signed [11:0] i_imm;
   logic signed [11:0] s_imm;
   logic signed [12:0] b_imm;
   logic signed [20:0] j_imm;
   logic signed [31:0] u_imm;

   assign i_imm = instr[31:20];
   assign s_imm = {instr[31:25], instr[11:7]};
   assign b_imm = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign j_imm = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign u_imm = {instr[31:12], 12'b0};

   always_comb begin
      imm = '0;
      case (instr[6:0])
         INSTR_TYPE_I, INSTR_TYPE_IL, INSTR_TYPE_JR: imm = XLEN'(i_imm);
         INSTR_TYPE_S:                               imm = XLEN'(s_imm);
         INSTR_TYPE_B:                               imm = XLEN'(b_imm);
         INSTR_TYPE_J:                               imm = XLEN'(j_imm);
         INSTR_TYPE_U, INSTR_TYPE_UPC:               imm = XLEN'(u_imm);
         default:                                    imm = '0;
      endcase
   end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with one ID/EX register, WB bypass, load-use bubble insertion and flush.
// Define ID_RV32M_EN to accept funct7=0000001 R-type as MUL/DIV (adds the 'mdu' control MSB).
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int CTRL_W = id_pkg::CTRL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid_i,
   output logic              if_ready_o,
   input  logic [31:0]       if_instr_i,
   input  logic [XLEN-1:0]   if_pc_i,
   input  logic              flush_i,
   output logic [REG_AW-1:0] rf_rs1_addr_o,
   output logic [REG_AW-1:0] rf_rs2_addr_o,
   input  logic [XLEN-1:0]   rf_rs1_data_i,
   input  logic [XLEN-1:0]   rf_rs2_data_i,
   input  logic              wb_wen_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [XLEN-1:0]   wb_data_i,
   input  logic              ex_memread_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   output logic              ex_valid_o,
   input  logic              ex_ready_i,
   output logic [XLEN-1:0]   ex_pc_o,
   output logic [XLEN-1:0]   ex_rs1_data_o,
   output logic [XLEN-1:0]   ex_rs2_data_o,
   output logic [XLEN-1:0]   ex_imm_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic [3:0]        ex_funct_o,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic              ex_illegal_o
);

   logic [6:0]        opc;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic              uses_rs1, uses_rs2, illegal_d;
   logic [CTRL_W-1:0] ctrl_d;
   logic [3:0]        funct_d;
   logic [REG_AW-1:0] rd_d, rs1_a, rs2_a;
   logic [XLEN-1:0]   imm_d, rs1_d, rs2_d;
   logic              adv, hz;

   logic              vld_p1, illegal_p1;
   logic [XLEN-1:0]   pc_p1, rs1_p1, rs2_p1, imm_p1;
   logic [REG_AW-1:0] rd_p1;
   logic [3:0]        funct_p1;
   logic [CTRL_W-1:0] ctrl_p1;

   // WB bypass; x0 and unused sources always read zero
   function automatic logic [XLEN-1:0] read_operand(input logic [REG_AW-1:0] a,
                                                    input logic [XLEN-1:0]   rf_d,
                                                    input logic              wen,
                                                    input logic [REG_AW-1:0] wrd,
                                                    input logic [XLEN-1:0]   wd);
      if (a == '0)
         return '0;
      else if (wen && wrd == a)
         return wd;
      else
         return rf_d;
   endfunction

   assign opc    = if_instr_i[6:0];
   assign funct3 = if_instr_i[14:12];
   assign funct7 = if_instr_i[31:25];

   always_comb begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      illegal_d = 1'b0;
      ctrl_d    = '0;
      funct_d   = {1'b0, funct3};
      rd_d      = if_instr_i[7 +: REG_AW];
      case (opc)
         INSTR_TYPE_R: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            if (funct7 == FUNCT7_MULDIV) begin
`ifdef ID_RV32M_EN
               ctrl_d[CTRL_MDU]      = 1'b1;
               ctrl_d[CTRL_REGWRITE] = 1'b1;
`else
               illegal_d = 1'b1;
`endif
            end else begin
               ctrl_d[CTRL_REGWRITE] = 1'b1;
               funct_d               = {funct7[5], funct3};
            end
         end
         INSTR_TYPE_I: begin
            uses_rs1              = 1'b1;
            ctrl_d[CTRL_ALUSRC]   = 1'b1;
            ctrl_d[CTRL_REGWRITE] = 1'b1;
            // funct7[5] only distinguishes SRAI from SRLI
            if (funct3 == 3'b101)
               funct_d = {funct7[5], funct3};
         end
         INSTR_TYPE_IL: begin
            uses_rs1              = 1'b1;
            ctrl_d[CTRL_ALUSRC]   = 1'b1;
            ctrl_d[CTRL_MEMREAD]  = 1'b1;
            ctrl_d[CTRL_MEMTOREG] = 1'b1;
            ctrl_d[CTRL_REGWRITE] = 1'b1;
         end
         INSTR_TYPE_S: begin
            uses_rs1              = 1'b1;
            uses_rs2              = 1'b1;
            ctrl_d[CTRL_ALUSRC]   = 1'b1;
            ctrl_d[CTRL_MEMWRITE] = 1'b1;
            rd_d                  = '0;
         end
         INSTR_TYPE_B: begin
            uses_rs1            = 1'b1;
            uses_rs2            = 1'b1;
            ctrl_d[CTRL_BRANCH] = 1'b1;
            rd_d                = '0;
         end
         INSTR_TYPE_J: begin
            ctrl_d[CTRL_JUMP]     = 1'b1;
            ctrl_d[CTRL_REGWRITE] = 1'b1;
         end
         INSTR_TYPE_JR: begin
            uses_rs1              = 1'b1;
            ctrl_d[CTRL_JUMP]     = 1'b1;
            ctrl_d[CTRL_REGWRITE] = 1'b1;
            ctrl_d[CTRL_ALUSRC]   = 1'b1;
         end
         INSTR_TYPE_U, INSTR_TYPE_UPC: begin
            ctrl_d[CTRL_ALUSRC]   = 1'b1;
            ctrl_d[CTRL_REGWRITE] = 1'b1;
         end
         default: illegal_d = 1'b1;
      endcase
   end

   assign rs1_a         = uses_rs1 ? if_instr_i[15 +: REG_AW] : '0;
   assign rs2_a         = uses_rs2 ? if_instr_i[20 +: REG_AW] : '0;
   assign rf_rs1_addr_o = rs1_a;
   assign rf_rs2_addr_o = rs2_a;

   assign rs1_d = read_operand(rs1_a, rf_rs1_data_i, wb_wen_i, wb_rd_i, wb_data_i);
   assign rs2_d = read_operand(rs2_a, rf_rs2_data_i, wb_wen_i, wb_rd_i, wb_data_i);

   id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (if_instr_i),
      .imm   (imm_d)
   );

   assign adv = !vld_p1 || ex_ready_i;
   assign hz  = if_valid_i && ex_memread_i && (ex_rd_i != '0) &&
                ((ex_rd_i == rs1_a && uses_rs1) || (ex_rd_i == rs2_a && uses_rs2));
   assign if_ready_o = flush_i || (adv && !hz);

   // ---- ID -> EX register boundary ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         pc_p1      <= '0;
         rs1_p1     <= '0;
         rs2_p1     <= '0;
         imm_p1     <= '0;
         rd_p1      <= '0;
         funct_p1   <= '0;
         ctrl_p1    <= '0;
         illegal_p1 <= 1'b0;
      end else if (flush_i) begin
         vld_p1 <= 1'b0;
      end else if (adv && hz) begin
         vld_p1 <= 1'b0;
      end else if (adv) begin
         vld_p1 <= if_valid_i;
         if (if_valid_i) begin
            pc_p1      <= if_pc_i;
            rs1_p1     <= rs1_d;
            rs2_p1     <= rs2_d;
            imm_p1     <= imm_d;
            rd_p1      <= rd_d;
            funct_p1   <= funct_d;
            ctrl_p1    <= ctrl_d;
            illegal_p1 <= illegal_d;
         end
      end
   end

   assign ex_valid_o    = vld_p1;
   assign ex_pc_o       = pc_p1;
   assign ex_rs1_data_o = rs1_p1;
   assign ex_rs2_data_o = rs2_p1;
   assign ex_imm_o      = imm_p1;
   assign ex_rd_o       = rd_p1;
   assign ex_funct_o    = funct_p1;
   assign ex_ctrl_o     = ctrl_p1;
   assign ex_illegal_o  = illegal_p1;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed scoreboard bench for id_stage_pipe; expectations follow ID_RV32M_EN when it is defined.
module tb_id_stage_pipe;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
`ifdef ID_RV32M_EN
   localparam int CW = 8;
`else
   localparam int CW = 7;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              if_valid_i, if_ready_o, flush_i;
   logic [31:0]       if_instr_i;
   logic [XLEN-1:0]   if_pc_i;
   logic [REG_AW-1:0] rf_rs1_addr_o, rf_rs2_addr_o;
   logic [XLEN-1:0]   rf_rs1_data_i, rf_rs2_data_i;
   logic              wb_wen_i;
   logic [REG_AW-1:0] wb_rd_i;
   logic [XLEN-1:0]   wb_data_i;
   logic              ex_memread_i;
   logic [REG_AW-1:0] ex_rd_i;
   logic              ex_valid_o, ex_ready_i;
   logic [XLEN-1:0]   ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [REG_AW-1:0] ex_rd_o;
   logic [3:0]        ex_funct_o;
   logic [CW-1:0]     ex_ctrl_o;
   logic              ex_illegal_o;

   id_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
      .flush_i(flush_i),
      .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
      .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
      .wb_wen_i(wb_wen_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
      .ex_imm_o(ex_imm_o), .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o),
      .ex_ctrl_o(ex_ctrl_o), .ex_illegal_o(ex_illegal_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  rd;
      logic [3:0]  funct;
      logic [7:0]  ctrl;
      logic        ill;
      bit          co, ci, cf;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] rd,
                               input logic [3:0] funct, input logic [7:0] ctrl, input logic ill,
                               input bit co, ci, cf);
      exp_t e;
      e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd;
      e.funct = funct; e.ctrl = ctrl; e.ill = ill; e.co = co; e.ci = ci; e.cf = cf;
      return e;
   endfunction

   task automatic cmp(input exp_t e, input string tag);
      chk({tag, "_pc"}, ex_pc_o, e.pc);
      chk({tag, "_ctrl"}, 32'(ex_ctrl_o), 32'(e.ctrl));
      chk({tag, "_illegal"}, 32'(ex_illegal_o), 32'(e.ill));
      if (e.co) begin
         chk({tag, "_rs1"}, ex_rs1_data_o, e.rs1);
         chk({tag, "_rs2"}, ex_rs2_data_o, e.rs2);
         chk({tag, "_rd"}, 32'(ex_rd_o), 32'(e.rd));
      end
      if (e.ci) chk({tag, "_imm"}, ex_imm_o, e.imm);
      if (e.cf) chk({tag, "_funct"}, 32'(ex_funct_o), 32'(e.funct));
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      chk({tag, "_valid"}, 32'(ex_valid_o), 32'd1);
      n_assert++;
      assert (sb.size() != 0) else begin
         n_fail++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         cmp(e, tag);
         last = e;
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
      if_valid_i = 1'b1;
      if_instr_i = instr;
      if_pc_i    = pc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] tbl_instr[9];
   exp_t        tbl_exp[9];
   string       tbl_tag[9];

   initial begin
      rst_n = 1'b1;
      if_valid_i = 1'b0; if_instr_i = '0; if_pc_i = '0; flush_i = 1'b0;
      rf_rs1_data_i = '0; rf_rs2_data_i = '0;
      wb_wen_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
      ex_memread_i = 1'b0; ex_rd_i = '0; ex_ready_i = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_valid", 32'(ex_valid_o), 32'd0);
      chk("rst_pc", ex_pc_o, 32'd0);
      chk("rst_imm", ex_imm_o, 32'd0);
      chk("rst_ctrl", 32'(ex_ctrl_o), 32'd0);
      chk("rst_illegal", 32'(ex_illegal_o), 32'd0);
      chk("rst_if_ready", 32'(if_ready_o), 32'd1);
      tick();
      rst_n = 1'b1;

      // addi x1,x0,5 : x0 source reads zero despite rf data
      drive(32'h00500093, 32'h100);
      rf_rs1_data_i = 32'h12345678; rf_rs2_data_i = 32'h9999;
      #1;
      chk("addi_rs1a", 32'(rf_rs1_addr_o), 32'd0);
      chk("addi_rs2a", 32'(rf_rs2_addr_o), 32'd0);
      chk("addi_if_ready", 32'(if_ready_o), 32'd1);
      sb.push_back(mk(32'h100, 0, 0, 32'd5, 5'd1, 4'h0, 8'h41, 1'b0, 1, 1, 1));
      tick();
      pop_check("addi");

      // lw x2,0(x1)
      drive(32'h0000A103, 32'h104);
      rf_rs1_data_i = 32'h55; rf_rs2_data_i = 32'h0;
      #1;
      chk("lw_rs1a", 32'(rf_rs1_addr_o), 32'd1);
      chk("lw_rs2a", 32'(rf_rs2_addr_o), 32'd0);
      sb.push_back(mk(32'h104, 32'h55, 0, 32'd0, 5'd2, 4'b0010, 8'h4D, 1'b0, 1, 1, 1));
      tick();
      pop_check("lw");

      // add x3,x2,x2 behind the load -> one bubble, then issue with WB bypass
      drive(32'h002101B3, 32'h108);
      ex_memread_i = 1'b1; ex_rd_i = 5'd2;
      rf_rs1_data_i = '0; rf_rs2_data_i = '0;
      #1;
      chk("lu_if_ready", 32'(if_ready_o), 32'd0);
      chk("add_rs1a", 32'(rf_rs1_addr_o), 32'd2);
      chk("add_rs2a", 32'(rf_rs2_addr_o), 32'd2);
      tick();
      chk("lu_bubble", 32'(ex_valid_o), 32'd0);
      ex_memread_i = 1'b0; ex_rd_i = '0;
      wb_wen_i = 1'b1; wb_rd_i = 5'd2; wb_data_i = 32'hDEADBEEF;
      #1;
      chk("lu_if_ready2", 32'(if_ready_o), 32'd1);
      sb.push_back(mk(32'h108, 32'hDEADBEEF, 32'hDEADBEEF, 0, 5'd3, 4'h0, 8'h01, 1'b0, 1, 0, 1));
      tick();
      pop_check("add");
      wb_wen_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;

      // back-pressure for 3 cycles: outputs frozen, IF stalled
      ex_ready_i = 1'b0;
      drive(32'h402082B3, 32'h10C);
      rf_rs1_data_i = 32'h10; rf_rs2_data_i = 32'h20;
      #1;
      chk("stall_if_ready", 32'(if_ready_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_valid", 32'(ex_valid_o), 32'd1);
         chk("hold_if_ready", 32'(if_ready_o), 32'd0);
         cmp(last, "hold");
      end
      ex_ready_i = 1'b1;
      #1;
      chk("resume_if_ready", 32'(if_ready_o), 32'd1);
      sb.push_back(mk(32'h10C, 32'h10, 32'h20, 0, 5'd5, 4'b1000, 8'h01, 1'b0, 1, 0, 1));
      tick();
      pop_check("sub");

      // remaining formats; rf x1=0x10, x2=0x20
      tbl_instr[0] = 32'h0020A423; tbl_tag[0] = "sw";
      tbl_exp[0]   = mk(32'h110, 32'h10, 32'h20, 32'd8, 5'd0, 4'b0010, 8'h42, 1'b0, 1, 1, 1);
      tbl_instr[1] = 32'h00208863; tbl_tag[1] = "beq_pos";
      tbl_exp[1]   = mk(32'h114, 32'h10, 32'h20, 32'd16, 5'd0, 4'b0000, 8'h10, 1'b0, 1, 1, 1);
      tbl_instr[2] = 32'hFE000CE3; tbl_tag[2] = "beq_neg";
      tbl_exp[2]   = mk(32'h118, 0, 0, 32'hFFFFFFF8, 5'd0, 4'b0000, 8'h10, 1'b0, 1, 1, 1);
      tbl_instr[3] = 32'h008000EF; tbl_tag[3] = "jal";
      tbl_exp[3]   = mk(32'h11C, 0, 0, 32'd8, 5'd1, 4'h0, 8'h21, 1'b0, 1, 1, 0);
      tbl_instr[4] = 32'h12345337; tbl_tag[4] = "lui";
      tbl_exp[4]   = mk(32'h120, 0, 0, 32'h12345000, 5'd6, 4'h0, 8'h41, 1'b0, 1, 1, 0);
      tbl_instr[5] = 32'h4030D393; tbl_tag[5] = "srai";
      tbl_exp[5]   = mk(32'h124, 32'h10, 0, 32'h403, 5'd7, 4'b1101, 8'h41, 1'b0, 1, 1, 1);
      tbl_instr[6] = 32'hC0008413; tbl_tag[6] = "addi_neg";
      tbl_exp[6]   = mk(32'h128, 32'h10, 0, 32'hFFFFFC00, 5'd8, 4'b0000, 8'h41, 1'b0, 1, 1, 1);
      tbl_instr[7] = 32'h022081B3; tbl_tag[7] = "mul";
`ifdef ID_RV32M_EN
      tbl_exp[7]   = mk(32'h12C, 32'h10, 32'h20, 0, 5'd3, 4'b0000, 8'h81, 1'b0, 1, 0, 1);
`else
      tbl_exp[7]   = mk(32'h12C, 0, 0, 0, 5'd0, 4'h0, 8'h00, 1'b1, 0, 0, 0);
`endif
      tbl_instr[8] = 32'hFFFFFFFF; tbl_tag[8] = "bad_opc";
      tbl_exp[8]   = mk(32'h130, 0, 0, 0, 5'd0, 4'h0, 8'h00, 1'b1, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         drive(tbl_instr[i], tbl_exp[i].pc);
         sb.push_back(tbl_exp[i]);
         tick();
         pop_check(tbl_tag[i]);
      end

      // flush with a full, stalled ID/EX and a valid incoming instruction
      ex_ready_i = 1'b0;
      drive(32'h00500093, 32'h134);
      flush_i = 1'b1;
      #1;
      chk("flush_if_ready", 32'(if_ready_o), 32'd1);
      tick();
      chk("flush_valid", 32'(ex_valid_o), 32'd0);
      flush_i = 1'b0; if_valid_i = 1'b0; ex_ready_i = 1'b1;
      tick();
      chk("flush_dropped", 32'(ex_valid_o), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      // async reset in the middle of a stall
      drive(32'h0000A103, 32'h140);
      rf_rs1_data_i = 32'h77;
      sb.push_back(mk(32'h140, 32'h77, 0, 32'd0, 5'd2, 4'b0010, 8'h4D, 1'b0, 1, 1, 1));
      tick();
      pop_check("lw2");
      if_valid_i = 1'b0; ex_ready_i = 1'b0;
      tick();
      chk("pre_rst_valid", 32'(ex_valid_o), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(ex_valid_o), 32'd0);
      chk("mid_rst_pc", ex_pc_o, 32'd0);
      chk("mid_rst_rs1", ex_rs1_data_o, 32'd0);
      chk("mid_rst_rs2", ex_rs2_data_o, 32'd0);
      chk("mid_rst_imm", ex_imm_o, 32'd0);
      chk("mid_rst_rd", 32'(ex_rd_o), 32'd0);
      chk("mid_rst_funct", 32'(ex_funct_o), 32'd0);
      chk("mid_rst_ctrl", 32'(ex_ctrl_o), 32'd0);
      chk("mid_rst_illegal", 32'(ex_illegal_o), 32'd0);
      chk("mid_rst_if_ready", 32'(if_ready_o), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", 32'(ex_valid_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
